// File: rtl/adbg_wb_burst_pkg.sv
// adbg_wb_burst_pkg
// Shared types and constants for the debug-unit Wishbone burst BIU:
//   - state_e        : BIU control FSM states
//   - CTI_* / BTE_*  : Wishbone cycle-type and burst-type encodings
//   - SIZE_*         : command size encodings (bytes per beat)
//   - size_to_log2() : maps a command size to log2(bytes), clamped to the bus width
package adbg_wb_burst_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDAT  = 3'd1,
    XFER  = 3'd2,
    RHOLD = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  localparam logic [3:0] SIZE_BYTE   = 4'd1;
  localparam logic [3:0] SIZE_HALF   = 4'd2;
  localparam logic [3:0] SIZE_WORD   = 4'd4;
  localparam logic [3:0] SIZE_DWORD  = 4'd8;

  // Unsupported size codes fall back to single bytes; anything wider than
  // the bus is narrowed to a full bus word.
  function automatic logic [1:0] size_to_log2(input logic [3:0] size,
                                              input logic [1:0] max_log);
    logic [1:0] l;
    case (size)
      SIZE_DWORD: l = 2'd3;
      SIZE_WORD:  l = 2'd2;
      SIZE_HALF:  l = 2'd1;
      default:    l = 2'd0;
    endcase
    if (l > max_log) l = max_log;
    return l;
  endfunction

endpackage

// File: rtl/adbg_wb_lane_steer.sv
// adbg_wb_lane_steer
// Combinational byte-lane steering for the Wishbone burst BIU.
//   size_log  : log2(bytes per beat)
//   addr_lo   : low byte-address bits of the current beat (force-aligned here)
//   wdata_in  : write beat, short words in the upper bits
//   bus_rdata : raw Wishbone read data
//   sel       : decoded Wishbone byte selects
//   bus_wdata : write data moved onto the selected lanes, other lanes zero
//   rdata_out : selected read lanes moved to the LSBs, upper bits zero
// BIG_ENDIAN=1 places the lowest byte address on the most-significant lane.
module adbg_wb_lane_steer #(
  parameter int DW         = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  localparam int SW        = DW / 8,
  localparam int SAW       = $clog2(SW)
) (
  input  logic [1:0]     size_log,
  input  logic [SAW-1:0] addr_lo,
  input  logic [DW-1:0]  wdata_in,
  input  logic [DW-1:0]  bus_rdata,
  output logic [SW-1:0]  sel,
  output logic [DW-1:0]  bus_wdata,
  output logic [DW-1:0]  rdata_out
);

  always_comb begin
    int nb;
    int off;
    int base;
    nb        = 1 << size_log;
    // Misaligned addresses are silently aligned down to the access size.
    off       = int'(addr_lo) & ~(nb - 1);
    // base is the lowest lane index touched by this access.
    base      = BIG_ENDIAN ? (SW - off - nb) : off;
    sel       = '0;
    bus_wdata = '0;
    rdata_out = '0;
    for (int i = 0; i < SW; i++) begin
      if ((i >= base) && (i < base + nb)) begin
        sel[i] = 1'b1;
        // Source bytes are the top nb bytes of wdata_in, numeric order kept.
        bus_wdata[8*i +: 8] = wdata_in[8*(SW - nb + i - base) +: 8];
      end
      if (i < nb) begin
        rdata_out[8*i +: 8] = bus_rdata[8*(base + i) +: 8];
      end
    end
  end

endmodule

// File: rtl/adbg_wb_burst_biu.sv
// adbg_wb_burst_biu
// Wishbone master bus interface unit for the debug unit. Executes one command
// (single access or incrementing burst of up to MAX_BURST beats) at a time,
// entirely in the Wishbone clock domain.
//   cmd_*      : command handshake (address, size, direction, length)
//   wdata_*    : write beat stream in (valid/ready)
//   rdata_*    : read beat stream out (valid/ready), right-justified
//   done_o     : one-cycle pulse when a command ends
//   err_o      : sticky bus error, cleared on next command accept
//   beats_o    : beats acknowledged in the last command
//   wb_*       : Wishbone B4 master port
// Optional build macro ADBG_WB_TIMEOUT_EN adds a TIMEOUT_CYC watchdog that
// aborts a stalled strobe with an error.
module adbg_wb_burst_biu #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_BURST   = 16,
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CW         = $clog2(MAX_BURST + 1),
  localparam int SW         = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [3:0]    cmd_size_i,
  input  logic          cmd_rd_wrn_i,
  input  logic [CW-1:0] cmd_len_i,
  input  logic          wdata_valid_i,
  output logic          wdata_ready_o,
  input  logic [DW-1:0] wdata_i,
  output logic          rdata_valid_o,
  input  logic          rdata_ready_i,
  output logic [DW-1:0] rdata_o,
  output logic          done_o,
  output logic          err_o,
  output logic [CW-1:0] beats_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [SW-1:0] wb_sel_o,
  output logic          wb_we_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o
);

  import adbg_wb_burst_pkg::*;

  localparam int         SAW = $clog2(SW);
  localparam logic [1:0] SWL = 2'(SAW);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [1:0]      szl_q;
  logic            we_q;
  logic            burst_q;
  logic [CW-1:0]   left_q;
  logic [CW-1:0]   beats_q;
  logic            err_q;
  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic [DW-1:0]   wdat_q;

  logic [1:0]      cmd_szl;
  logic [AW-1:0]   cmd_addr_al;
  logic [CW-1:0]   len_eff;
  logic            cmd_fire, wdat_fire, bus_err, bus_ack, last_beat, rd_room;
  logic            timeout;

  logic [SW-1:0]   steer_sel;
  logic [DW-1:0]   steer_wdata, steer_rdata;

  adbg_wb_lane_steer #(
    .DW         (DW),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_steer (
    .size_log  (szl_q),
    .addr_lo   (addr_q[SAW-1:0]),
    .wdata_in  (wdata_i),
    .bus_rdata (wb_dat_i),
    .sel       (steer_sel),
    .bus_wdata (steer_wdata),
    .rdata_out (steer_rdata)
  );

  assign cmd_szl     = size_to_log2(cmd_size_i, SWL);
  assign cmd_addr_al = cmd_addr_i & ~((AW'(1) << cmd_szl) - AW'(1));

  always_comb begin
    if (cmd_len_i == '0)                   len_eff = CW'(1);
    else if (cmd_len_i > CW'(MAX_BURST))   len_eff = CW'(MAX_BURST);
    else                                   len_eff = cmd_len_i;
  end

  assign cmd_fire  = (state_q == IDLE) && cmd_valid_i;
  assign wdat_fire = (state_q == WDAT) && wdata_valid_i;
  // Error (or watchdog) beats ack in the same cycle; that beat is not counted.
  assign bus_err   = (state_q == XFER) && (wb_err_i || timeout);
  assign bus_ack   = (state_q == XFER) && wb_ack_i && !bus_err;
  assign last_beat = (left_q == CW'(1));
  // The read register can take a beat next cycle if empty or draining now.
  assign rd_room   = !rvalid_q || rdata_ready_i;

`ifdef ADBG_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q;

  // Zero outside XFER, so every strobe rise starts a fresh count.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      to_cnt_q <= '0;
    end else if ((state_q != XFER) || wb_ack_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end

  // Fires on the TIMEOUT_CYC-th strobe cycle, so stb is high exactly that long.
  assign timeout = (state_q == XFER) && !wb_ack_i &&
                   (to_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
  // Watchdog compiled out; constant 0 for any legal TIMEOUT_CYC.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (!cmd_rd_wrn_i) state_d = WDAT;
          // A previous read beat may still be unclaimed; hold the bus in
          // RHOLD until it drains instead of strobing into a full register.
          else if (rd_room)  state_d = XFER;
          else               state_d = RHOLD;
        end
      end
      WDAT: begin
        if (wdata_valid_i) state_d = XFER;
      end
      XFER: begin
        if (bus_err)        state_d = DONE;
        else if (bus_ack) begin
          if (last_beat)    state_d = DONE;
          else if (we_q)    state_d = WDAT;
          else              state_d = RHOLD;
        end
      end
      RHOLD: begin
        if (rd_room) state_d = XFER;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      addr_q   <= '0;
      szl_q    <= '0;
      we_q     <= 1'b0;
      burst_q  <= 1'b0;
      left_q   <= '0;
      beats_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      wdat_q   <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q  <= cmd_addr_al;
        szl_q   <= cmd_szl;
        we_q    <= !cmd_rd_wrn_i;
        left_q  <= len_eff;
        burst_q <= (len_eff != CW'(1));
        beats_q <= '0;
        err_q   <= 1'b0;
      end
      if (wdat_fire) wdat_q <= steer_wdata;
      if (bus_err)   err_q  <= 1'b1;
      if (bus_ack) begin
        beats_q <= beats_q + CW'(1);
        left_q  <= left_q - CW'(1);
        addr_q  <= addr_q + (AW'(1) << szl_q);
      end
      if (bus_ack && !we_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= steer_rdata;
      end else if (rvalid_q && rdata_ready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign wdata_ready_o = (state_q == WDAT);
  assign done_o        = (state_q == DONE);
  assign wb_cyc_o      = (state_q == XFER) || (state_q == RHOLD);
  assign wb_stb_o      = (state_q == XFER);
  assign wb_we_o       = we_q && wb_cyc_o;
  assign wb_sel_o      = wb_stb_o ? steer_sel : '0;
  assign wb_adr_o      = addr_q;
  assign wb_dat_o      = wdat_q;
  assign wb_bte_o      = BTE_LINEAR;
  assign rdata_valid_o = rvalid_q;
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign beats_o       = beats_q;

  // Incrementing bursts only for full-width multi-beat commands.
  always_comb begin
    wb_cti_o = CTI_CLASSIC;
    if (wb_stb_o && burst_q && (szl_q == SWL)) begin
      wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;
    end
  end

endmodule

// File: tb/tb_adbg_wb_burst_biu.sv
module tb_adbg_wb_burst_biu;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 5;
  localparam int SW = 4;

  logic          wb_clk_i, wb_rst_ni;
  logic          cmd_valid_i, cmd_ready_o, cmd_rd_wrn_i;
  logic [AW-1:0] cmd_addr_i;
  logic [3:0]    cmd_size_i;
  logic [CW-1:0] cmd_len_i;
  logic          wdata_valid_i, wdata_ready_o;
  logic [DW-1:0] wdata_i;
  logic          rdata_valid_o, rdata_ready_i;
  logic [DW-1:0] rdata_o;
  logic          done_o, err_o;
  logic [CW-1:0] beats_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
  logic [SW-1:0] wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;

  adbg_wb_burst_biu #(
    .AW(AW), .DW(DW), .MAX_BURST(16), .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(16)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_size_i(cmd_size_i), .cmd_rd_wrn_i(cmd_rd_wrn_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
    .done_o(done_o), .err_o(err_o), .beats_o(beats_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
  } bus_exp_t;

  typedef struct {
    logic       err;
    logic [4:0] beats;
  } done_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] rd_q[$];
  done_exp_t   done_q[$];

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int stb_cycles = 0;

  // slave behaviour knobs (written by the main sequence only)
  int          slv_ws = 0;
  int          slv_err_beat = -1;
  bit          slv_silent = 1'b0;
  bit          slv_fixed_en = 1'b0;
  logic [31:0] slv_fixed = 32'h0;
  // slave state (written by the slave only)
  int          slv_beat = 0;
  int          slv_wait = 0;

  // rdata stall request (main sets, driver consumes)
  int stall_req = 0;
  int stall_at  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] s, input logic [2:0] c,
                          input logic w, input logic [31:0] d);
    bus_exp_t e;
    e.adr = a; e.sel = s; e.cti = c; e.we = w; e.dat = d;
    bus_q.push_back(e);
  endtask

  task automatic push_done(input logic e, input logic [4:0] b);
    done_exp_t d;
    d.err = e; d.beats = b;
    done_q.push_back(d);
  endtask

  // Wishbone slave: configurable wait states, error beat, fixed or address-derived data.
  initial begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_stb_o && !slv_silent) begin
        if (slv_wait >= slv_ws) begin
          slv_wait = 0;
          if (slv_beat == slv_err_beat) begin
            wb_err_i = 1'b1;
          end else begin
            wb_ack_i = 1'b1;
            wb_dat_i = slv_fixed_en ? slv_fixed : (32'hC0DE0000 | {16'h0, wb_adr_o[15:0]});
          end
          slv_beat++;
        end else begin
          slv_wait++;
        end
      end else begin
        slv_wait = 0;
      end
    end
  end

  // rdata_ready_i driver: normally high; one 5-cycle stall per request.
  initial begin
    int stall_seen;
    stall_seen = 0;
    rdata_ready_i = 1'b1;
    forever begin
      @(posedge wb_clk_i);
      #2;
      if ((stall_req > stall_seen) && (rd_cnt >= stall_at)) begin
        stall_seen = stall_req;
        rdata_ready_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("hold_cyc",   64'(wb_cyc_o),      64'h1);
        chk("hold_stb",   64'(wb_stb_o),      64'h0);
        chk("hold_valid", 64'(rdata_valid_o), 64'h1);
        repeat (2) @(posedge wb_clk_i);
        #2;
        rdata_ready_i = 1'b1;
      end
    end
  end

  // Monitor: bus beats, read beats and done pulses against the scoreboards.
  always @(negedge wb_clk_i) begin : mon
    bus_exp_t  be;
    done_exp_t de;
    logic [31:0] re;
    if (wb_rst_ni) begin
      if (wb_stb_o) stb_cycles++;
      if (wb_stb_o && (wb_ack_i || wb_err_i)) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected: got beat at %0h want none", wb_adr_o);
        end else begin
          be = bus_q.pop_front();
          chk("bus_adr", 64'(wb_adr_o), 64'(be.adr));
          chk("bus_sel", 64'(wb_sel_o), 64'(be.sel));
          chk("bus_cti", 64'(wb_cti_o), 64'(be.cti));
          chk("bus_we",  64'(wb_we_o),  64'(be.we));
          chk("bus_bte", 64'(wb_bte_o), 64'h0);
          if (be.we) chk("bus_dat", 64'(wb_dat_o), 64'(be.dat));
        end
      end
      if (rdata_valid_o && rdata_ready_i) begin
        rd_cnt++;
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rdata_unexpected: got %0h want none", rdata_o);
        end else begin
          re = rd_q.pop_front();
          chk("rdata", 64'(rdata_o), 64'(re));
        end
      end
      if (done_o) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got pulse want none");
        end else begin
          de = done_q.pop_front();
          chk("done_err",   64'(err_o),   64'(de.err));
          chk("done_beats", 64'(beats_o), 64'(de.beats));
          chk("done_cyc",   64'(wb_cyc_o), 64'h0);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [3:0] sz, input logic rd,
                       input logic [4:0] len);
    int n;
    n = 0;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_size_i = sz; cmd_rd_wrn_i = rd; cmd_len_i = len;
    while (!cmd_ready_o && n < 200) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (!cmd_ready_o) begin
      total++; bad++;
      $display("FAIL cmd_accept: got ready=0 want ready=1 within 200 cycles");
    end
    @(posedge wb_clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d);
    int n;
    n = 0;
    @(negedge wb_clk_i);
    wdata_valid_i = 1'b1; wdata_i = d;
    while (!wdata_ready_o && n < 200) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (!wdata_ready_o) begin
      total++; bad++;
      $display("FAIL wdata_accept: got ready=0 want ready=1 within 200 cycles");
    end
    @(posedge wb_clk_i);
    #1;
    wdata_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (done_cnt < target) begin
      total++; bad++;
      $display("FAIL done_wait: got %0d pulses want %0d", done_cnt, target);
    end
    repeat (2) @(negedge wb_clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    int base_stb;
    cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_size_i = '0; cmd_rd_wrn_i = 1'b0; cmd_len_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0;
    wb_rst_ni = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_cmd_ready",   64'(cmd_ready_o),   64'h1);
    chk("rst_wdata_ready", 64'(wdata_ready_o), 64'h0);
    chk("rst_rdata_valid", 64'(rdata_valid_o), 64'h0);
    chk("rst_rdata",       64'(rdata_o),       64'h0);
    chk("rst_done",        64'(done_o),        64'h0);
    chk("rst_err",         64'(err_o),         64'h0);
    chk("rst_beats",       64'(beats_o),       64'h0);
    chk("rst_cyc",         64'(wb_cyc_o),      64'h0);
    chk("rst_stb",         64'(wb_stb_o),      64'h0);
    chk("rst_sel",         64'(wb_sel_o),      64'h0);
    chk("rst_we",          64'(wb_we_o),       64'h0);
    chk("rst_cti",         64'(wb_cti_o),      64'h0);
    chk("rst_bte",         64'(wb_bte_o),      64'h0);
    chk("rst_adr",         64'(wb_adr_o),      64'h0);
    chk("rst_dat",         64'(wb_dat_o),      64'h0);
    wb_rst_ni = 1'b1;

    // single word write, 2 wait states
    slv_ws = 2;
    push_bus(32'h100, 4'hF, 3'b000, 1'b1, 32'hDEADBEEF);
    push_done(1'b0, 5'd1);
    issue(32'h100, 4'd4, 1'b0, 5'd1);
    send_w(32'hDEADBEEF);
    wait_done(1);

    // byte read at 0x103, big endian -> lane 0
    slv_ws = 0; slv_fixed_en = 1'b1; slv_fixed = 32'h11223344;
    push_bus(32'h103, 4'b0001, 3'b000, 1'b0, 32'h0);
    rd_q.push_back(32'h00000044);
    push_done(1'b0, 5'd1);
    issue(32'h103, 4'd1, 1'b1, 5'd1);
    wait_done(2);
    slv_fixed_en = 1'b0;

    // 4-beat incrementing read
    for (int i = 0; i < 4; i++) begin
      push_bus(32'h200 + 32'(4*i), 4'hF, (i == 3) ? 3'b111 : 3'b010, 1'b0, 32'h0);
      rd_q.push_back(32'hC0DE0200 + 32'(4*i));
    end
    push_done(1'b0, 5'd4);
    issue(32'h200, 4'd4, 1'b1, 5'd4);
    wait_done(3);

    // 8-beat read with a 5-cycle consumer stall after beat 2
    stall_at = rd_cnt + 2;
    stall_req++;
    for (int i = 0; i < 8; i++) begin
      push_bus(32'h300 + 32'(4*i), 4'hF, (i == 7) ? 3'b111 : 3'b010, 1'b0, 32'h0);
      rd_q.push_back(32'hC0DE0300 + 32'(4*i));
    end
    push_done(1'b0, 5'd8);
    issue(32'h300, 4'd4, 1'b1, 5'd8);
    wait_done(4);

    // 4-beat write, bus error on beat 3
    slv_err_beat = slv_beat + 2;
    push_bus(32'h400, 4'hF, 3'b010, 1'b1, 32'h11111111);
    push_bus(32'h404, 4'hF, 3'b010, 1'b1, 32'h22222222);
    push_bus(32'h408, 4'hF, 3'b010, 1'b1, 32'h33333333);
    push_done(1'b1, 5'd2);
    issue(32'h400, 4'd4, 1'b0, 5'd4);
    send_w(32'h11111111);
    send_w(32'h22222222);
    send_w(32'h33333333);
    wait_done(5);
    slv_err_beat = -1;

    // halfword write at 0x502: accept clears err, data steered to lanes 1:0
    push_bus(32'h502, 4'b0011, 3'b000, 1'b1, 32'h0000ABCD);
    push_done(1'b0, 5'd1);
    issue(32'h502, 4'd2, 1'b0, 5'd1);
    chk("err_clear_on_accept", 64'(err_o), 64'h0);
    send_w(32'hABCD0000);
    wait_done(6);

    // misaligned halfword read at 0x501 -> aligned to 0x500, lanes 3:2
    push_bus(32'h500, 4'b1100, 3'b000, 1'b0, 32'h0);
    rd_q.push_back(32'h0000C0DE);
    push_done(1'b0, 5'd1);
    issue(32'h501, 4'd2, 1'b1, 5'd1);
    wait_done(7);

    // length 0 behaves as a single beat
    push_bus(32'h600, 4'hF, 3'b000, 1'b0, 32'h0);
    rd_q.push_back(32'hC0DE0600);
    push_done(1'b0, 5'd1);
    issue(32'h600, 4'd4, 1'b1, 5'd0);
    wait_done(8);

    // length 31 clamps to 16 beats
    for (int i = 0; i < 16; i++) begin
      push_bus(32'h700 + 32'(4*i), 4'hF, (i == 15) ? 3'b111 : 3'b010, 1'b0, 32'h0);
      rd_q.push_back(32'hC0DE0700 + 32'(4*i));
    end
    push_done(1'b0, 5'd16);
    issue(32'h700, 4'd4, 1'b1, 5'd31);
    wait_done(9);

    // reset during a stalled transfer: bus released, no done pulse
    slv_silent = 1'b1;
    issue(32'h800, 4'd4, 1'b1, 5'd1);
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("midrst_cyc_before", 64'(wb_cyc_o), 64'h1);
    wb_rst_ni = 1'b0;
    #1;
    chk("midrst_cyc",   64'(wb_cyc_o),    64'h0);
    chk("midrst_stb",   64'(wb_stb_o),    64'h0);
    chk("midrst_ready", 64'(cmd_ready_o), 64'h1);
    @(negedge wb_clk_i);
    chk("midrst_done",  64'(done_o),      64'h0);
    wb_rst_ni = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    chk("midrst_done_count", 64'(done_cnt), 64'd9);

`ifdef ADBG_WB_TIMEOUT_EN
    // silent slave: watchdog aborts after 16 strobe cycles
    base_stb = stb_cycles;
    push_done(1'b1, 5'd0);
    issue(32'h900, 4'd4, 1'b1, 5'd1);
    wait_done(10);
    chk("timeout_stb_cycles", 64'(stb_cycles - base_stb), 64'd16);
`else
    base_stb = stb_cycles;
`endif
    slv_silent = 1'b0;

    repeat (4) @(negedge wb_clk_i);
    chk("bus_q_empty",  64'(bus_q.size()),  64'h0);
    chk("rd_q_empty",   64'(rd_q.size()),   64'h0);
    chk("done_q_empty", 64'(done_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
